mealy_seq_detector: RTL and testbench
=====================================

# mealy_seq_detector

Parametrised Mealy sequence detector that generalises the two-state "0 then 1" detector to an arbitrary serial bit pattern of configurable length. It accepts optional overlapping matches and can keep a saturating match counter. It sits after the board's debounced/strobed serial input in the day-1 lab designs and drives LEDs or the 7-segment display. Input bits are consumed one per enabled clock.

## Interface

- `PATTERN_LEN`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default `4'b1011`: pattern bits, `PATTERN_LEN` wide; MSB is the first bit expected on the wire.
- `OVERLAP`, default 1: 1 means matches may share bits; 0 means the detector restarts from empty after each match.
- `CNT_W`, default 8: match counter width; legal range 1..32.

Ports:

- `clk`  in  1: clock.
- `reset`  in  1: **synchronous, active-high reset**; sampled on the rising edge of `clk`.
- `en`  in  1: bit strobe; `a` is consumed only on cycles with `en`=1.
- `a`  in  1: serial input bit.
- `clr_cnt`  in  1: synchronous clear of the match counter.
- `y`  out  1: Mealy match output; combinational from state, `a`, `en` and `reset`.
- `match_cnt`  out  `CNT_W`: number of matches since reset or clear; saturating.
- `cnt_sat`  out  1: high while `match_cnt` equals all-ones.

## Operation

- State `s` = length of the longest suffix of the consumed bits that equals a prefix of `PATTERN`.
  - Range is 0..`PATTERN_LEN`-1.
  - Register width is `$clog2(PATTERN_LEN)`.
- Define `exp(s)` = `PATTERN[PATTERN_LEN-1-s]`, the next expected bit.
- Next state on an enabled cycle:
  - `a`==`exp(s)` and `s`<`PATTERN_LEN`-1: `s+1`.
  - `a`==`exp(s)` and `s`==`PATTERN_LEN`-1 (a match) with `OVERLAP`=1: `s` becomes the longest proper border of `PATTERN` (longest proper prefix that is also a suffix).
  - The same match with `OVERLAP`=0: `s` becomes 0.
  - Mismatch: `s` becomes the longest suffix of (prefix of length `s`, followed by `a`) that is also a pattern prefix. This is KMP failure-function behaviour and is precomputed at elaboration from `PATTERN`. It is not a blind reset to 0.
- Output: `y` = !`reset` & `en` & (`s`==`PATTERN_LEN`-1) & (`a`==`exp(s)`).
- With `en`=0:
  - `s` holds.
  - `y`=0.
  - Counter holds, except that `clr_cnt` still applies.
- Counter (only when `MEALY_SEQ_DET_CNT_EN` is defined):
  - On a clock edge with `y`=1, `match_cnt` increments.
  - At all-ones it stays at all-ones, and `cnt_sat`=1.
  - `clr_cnt`=1 sets `match_cnt` to 0 and `cnt_sat` to 0. This takes priority over a simultaneous match.
- Reset: `s`=0, `match_cnt`=0, `cnt_sat`=0; `y`=0 throughout the reset cycle. Reset overrides `en` and `clr_cnt`.

## Timing

- `y` has zero latency: it asserts in the same cycle as the final pattern bit on `a` while `en`=1.
- `match_cnt` reflects a match one cycle later, at the registered edge.
- Reset mid-pattern discards partial progress. The first bit after reset is compared against `PATTERN[PATTERN_LEN-1]`.
- Back-to-back enabled cycles are supported at the full clock rate. Gaps in `en` of any length do not alter detection.
- Wrap-around: the counter never wraps.

## Configuration

- `MEALY_SEQ_DET_CNT_EN` defined: the counter, `clr_cnt` logic and `cnt_sat` are built as described above.
- Not defined: no counter flops are built.
  - `match_cnt` and `cnt_sat` are tied to 0.
  - `clr_cnt` is ignored.
  - Detection and `y` are unchanged.

## Test plan

- Defaults, `OVERLAP`=1, `en`=1, input stream 1,0,1,1,0,1,1 → `y`=1 only on bits 4 and 7; `match_cnt`=2 one cycle after bit 7.
- `OVERLAP`=0, same stream → `y`=1 only on bit 4; `match_cnt`=1.
- Mismatch fallback, `PATTERN`=`4'b1011`, stream 1,0,1,0,1,1 → no false `y` on bit 4; `y`=1 on bit 6.
- `en` gaps: stream 1,0,1,1 with `en`=0 for 3 cycles between each bit, and `a` toggling freely in the gaps → `y`=1 only on the fourth enabled bit; `y`=0 on every `en`=0 cycle.
- Saturation and clear, `CNT_W`=2, 5 matches → `match_cnt` 1,2,3,3,3 and `cnt_sat`=1 from the third match; `clr_cnt` pulsed together with a 6th match → `match_cnt`=0 and `cnt_sat`=0.
- Reset after the first three pattern bits (1,0,1), then bit 1 → `y`=0 during and after reset; the full pattern must then be resent to obtain `y`=1; `match_cnt`=0 after reset.

Source files
------------

// File: rtl/mealy_seq_detector_if.sv
// Serial-detector bus: bit strobe, data bit and counter clear towards the
// detector, plus match pulse and match counter back from it.
interface mealy_seq_detector_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             a;
    logic             clr_cnt;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (output en, a, clr_cnt, input y, match_cnt, cnt_sat);
    modport slave  (input en, a, clr_cnt, output y, match_cnt, cnt_sat);
endinterface

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial-pattern detector with KMP-style fallback on
// mismatch and optional overlapping matches.
// Optional saturating match counter: define MEALY_SEQ_DET_CNT_EN to build it,
// otherwise match_cnt/cnt_sat are tied to 0 and clr_cnt is ignored.
//
// state s_q | meaning
// ----------+---------------------------------------------------------------
// 0         | no progress: next bit is compared with PATTERN[PATTERN_LEN-1]
// k         | the last k consumed bits equal the first k pattern bits
// LEN-1     | one bit short: a matching bit here asserts y
module mealy_seq_detector #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     OVERLAP     = 1,
    parameter int                     CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mealy_seq_detector_if.slave  bus
);
    localparam int SW    = $clog2(PATTERN_LEN);
    localparam int NS    = 2 ** SW;
    localparam int TBL_W = 2 * NS * SW;
    localparam logic [SW-1:0] LAST = SW'(PATTERN_LEN - 1);

    // exp(s) lookup, padded to a power of two so any s_q value indexes safely
    function automatic logic [NS-1:0] build_exp();
        logic [NS-1:0] e;
        e = '0;
        for (int s = 0; s < PATTERN_LEN; s++) begin
            e[s] = PATTERN[PATTERN_LEN-1-s];
        end
        return e;
    endfunction

    // Longest proper prefix of PATTERN that is also a suffix
    function automatic int border_len();
        int  best;
        logic ok;
        best = 0;
        for (int k = 1; k < PATTERN_LEN; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (PATTERN[k-1-i] != PATTERN[PATTERN_LEN-1-i]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Next-state table indexed by {s, a}; entry width SW
    function automatic logic [TBL_W-1:0] build_tbl();
        logic [TBL_W-1:0] t;
        int   best;
        int   j;
        logic bi;
        logic tj;
        logic ok;
        t = '0;
        for (int s = 0; s < PATTERN_LEN; s++) begin
            for (int b = 0; b < 2; b++) begin
                bi = (b == 1);
                best = 0;
                if (bi == PATTERN[PATTERN_LEN-1-s]) begin
                    if (s < PATTERN_LEN - 1) best = s + 1;
                    else if (OVERLAP != 0)   best = border_len();
                    else                     best = 0;
                end else begin
                    // longest suffix of (prefix_s, a) that is a pattern prefix
                    for (int k = 1; k <= s; k++) begin
                        ok = 1'b1;
                        for (int i = 0; i < k; i++) begin
                            j  = s + 1 - k + i;
                            tj = (j == s) ? bi : PATTERN[PATTERN_LEN-1-j];
                            if (tj != PATTERN[PATTERN_LEN-1-i]) ok = 1'b0;
                        end
                        if (ok) best = k;
                    end
                end
                t[(s*2+b)*SW +: SW] = SW'(best);
            end
        end
        return t;
    endfunction

    localparam logic [NS-1:0]    EXP_TBL  = build_exp();
    localparam logic [TBL_W-1:0] NEXT_TBL = build_tbl();

    logic [SW-1:0] s_q, s_d;
    logic          exp_bit;

    // Next-state lookup; state holds on cycles without a bit strobe
    always_comb begin
        exp_bit = EXP_TBL[s_q];
        s_d     = s_q;
        if (bus.en) begin
            s_d = NEXT_TBL[32'({s_q, bus.a}) * SW +: SW];
        end
    end

    assign bus.y = !reset && bus.en && (s_q == LAST) && (bus.a == exp_bit);

    // Progress register; reset discards any partial match
    always_ff @(posedge clk) begin
        if (reset) s_q <= '0;
        else       s_q <= s_d;
    end

`ifdef MEALY_SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match count; clear wins over a simultaneous match
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt)              cnt_d = '0;
        else if (bus.y && !(&cnt_q))  cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = &cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = bus.clr_cnt;
    assign bus.match_cnt  = '0;
    assign bus.cnt_sat    = 1'b0;
`endif
endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: three instances (overlap, non-overlap,
// overlap with a 2-bit counter) share one stimulus stream. The driver queues
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_mealy_seq_detector;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mealy_seq_detector_if #(.CNT_W(8)) if_ov ();
    mealy_seq_detector_if #(.CNT_W(8)) if_no ();
    mealy_seq_detector_if #(.CNT_W(2)) if_s  ();

    mealy_seq_detector #(.OVERLAP(1), .CNT_W(8)) dut_ov (.clk(clk), .reset(reset), .bus(if_ov));
    mealy_seq_detector #(.OVERLAP(0), .CNT_W(8)) dut_no (.clk(clk), .reset(reset), .bus(if_no));
    mealy_seq_detector #(.OVERLAP(1), .CNT_W(2)) dut_s  (.clk(clk), .reset(reset), .bus(if_s));

    typedef struct {
        int         idx;
        logic       y_ov;
        logic       y_no;
        logic [7:0] c_ov;
        logic [7:0] c_no;
        logic [1:0] c_s;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;
    int vec      = 0;
    logic [7:0] m_ov = '0;
    logic [7:0] m_no = '0;
    logic [1:0] m_s  = '0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, req);
        end
    endtask

    // One clock of stimulus; expected y is hand-computed, counters follow it
    task automatic step(input logic r, input logic e, input logic b, input logic c,
                        input logic ey_ov, input logic ey_no);
        exp_t x;
        @(posedge clk);
        #1;
        reset = r;
        if_ov.en = e; if_ov.a = b; if_ov.clr_cnt = c;
        if_no.en = e; if_no.a = b; if_no.clr_cnt = c;
        if_s.en  = e; if_s.a  = b; if_s.clr_cnt  = c;
        x.idx  = vec;
        x.y_ov = ey_ov;
        x.y_no = ey_no;
        x.c_ov = m_ov;
        x.c_no = m_no;
        x.c_s  = m_s;
        q.push_back(x);
        vec++;
`ifdef MEALY_SEQ_DET_CNT_EN
        if (r || c) begin
            m_ov = '0; m_no = '0; m_s = '0;
        end else begin
            if (ey_ov && m_ov != 8'hff) m_ov = m_ov + 8'd1;
            if (ey_no && m_no != 8'hff) m_no = m_no + 8'd1;
            if (ey_ov && m_s  != 2'b11) m_s  = m_s + 2'd1;
        end
`endif
    endtask

    // Enabled bits, MSB of the vectors first
    task automatic seq(input int n, input logic [15:0] bits, input logic [15:0] yo, input logic [15:0] yn);
        for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0, yo[i], yn[i]);
    endtask

    // Monitor: compare every queued expectation away from the active edge
    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("y_ov",   x.idx, 32'(if_ov.y),         32'(x.y_ov));
            chk("y_no",   x.idx, 32'(if_no.y),         32'(x.y_no));
            chk("y_s",    x.idx, 32'(if_s.y),          32'(x.y_ov));
            chk("cnt_ov", x.idx, 32'(if_ov.match_cnt), 32'(x.c_ov));
            chk("cnt_no", x.idx, 32'(if_no.match_cnt), 32'(x.c_no));
            chk("cnt_s",  x.idx, 32'(if_s.match_cnt),  32'(x.c_s));
            chk("sat_ov", x.idx, 32'(if_ov.cnt_sat),   32'(x.c_ov == 8'hff));
            chk("sat_no", x.idx, 32'(if_no.cnt_sat),   32'(x.c_no == 8'hff));
            chk("sat_s",  x.idx, 32'(if_s.cnt_sat),    32'(x.c_s == 2'b11));
        end
    end

    initial begin
        reset = 1'b1;
        if_ov.en = 1'b0; if_ov.a = 1'b0; if_ov.clr_cnt = 1'b0;
        if_no.en = 1'b0; if_no.a = 1'b0; if_no.clr_cnt = 1'b0;
        if_s.en  = 1'b0; if_s.a  = 1'b0; if_s.clr_cnt  = 1'b0;
        repeat (2) @(posedge clk);

        // overlapping vs restarting detection on 1011011
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        seq(7, 16'b1011011, 16'b0001001, 16'b0001000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // mismatch fallback on 101011: no false hit on bit 4
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        seq(6, 16'b101011, 16'b000001, 16'b000001);

        // en gaps with a toggling in between; a=1 while one bit short must not hit
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // saturation: repeated 1011, clear together with the 6th match
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 1; r <= 7; r++) begin
            if (r == 6) begin
                seq(3, 16'b101, 16'b000, 16'b000);
                step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            end else begin
                seq(4, 16'b1011, 16'b0001, 16'b0001);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-pattern, including on what would be the matching bit
        seq(3, 16'b101, 16'b000, 16'b000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        seq(4, 16'b1011, 16'b0001, 16'b0001);
        // clear still applies with en low
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
